// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port framebuffer SRAM between scanout reads (priority) and queued MCU pixel writes.
// Ports: system_clock/reset (async, active-high); write_address_load, write_address, pixel_valid, pixel_data,
//   fifo_full and sticky pixel_overflow on the MCU write side; read_request, read_address, read_data and
//   read_data_valid on the scanout side; mem_enable, mem_write_enable, mem_address, mem_write_data and
//   mem_read_data towards the SRAM.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FB_DEPTH    = 76800,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIXEL_WIDTH = 12
) (
  input  logic                   system_clock,
  input  logic                   reset,
  input  logic                   write_address_load,
  input  logic [ADDR_WIDTH-1:0]  write_address,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic                   fifo_full,
  output logic                   pixel_overflow,
  input  logic                   read_request,
  input  logic [ADDR_WIDTH-1:0]  read_address,
  output logic [PIXEL_WIDTH-1:0] read_data,
  output logic                   read_data_valid,
  output logic                   mem_enable,
  output logic                   mem_write_enable,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [PIXEL_WIDTH-1:0] mem_write_data,
  input  logic [PIXEL_WIDTH-1:0] mem_read_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE} grant_t;
  grant_t state, next_state;
  logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
  logic [PIXEL_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]          head, tail;
  logic [PW:0]            count;
  logic [ADDR_WIDTH-1:0]  write_pointer, base_address, next_pointer;
  logic                   push, pop, fifo_empty, result_pending;
  // Fullness is judged at cycle start, so a same-cycle pop never makes room for a push.
  always_comb begin
    fifo_empty       = count == '0;
    fifo_full        = count == (PW+1)'(FIFO_DEPTH);
    push             = pixel_valid & ~fifo_full;
    pop              = ~read_request & ~fifo_empty;
    base_address     = write_address_load ? write_address : write_pointer;
    next_pointer     = base_address == ADDR_WIDTH'(FB_DEPTH - 1) ? '0 : base_address + 1'b1;
    next_state       = read_request ? READ : fifo_empty ? IDLE : WRITE;
    mem_enable       = state != IDLE;
    mem_write_enable = state == WRITE;
  end
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mem_address     <= '0;
      mem_write_data  <= '0;
      write_pointer   <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      pixel_overflow  <= 1'b0;
      result_pending  <= 1'b0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (read_request) mem_address <= read_address;
      else if (pop) begin
        mem_address    <= fifo_addr[head];
        mem_write_data <= fifo_data[head];
        head           <= head + 1'b1;
      end
      if (push) begin
        tail          <= tail + 1'b1;
        write_pointer <= next_pointer;
      end else if (write_address_load) write_pointer <= write_address;
      count          <= count + (PW+1)'(push) - (PW+1)'(pop);
      pixel_overflow <= write_address_load ? 1'b0 : pixel_overflow | (pixel_valid & fifo_full);
      // SRAM data appears the cycle after the READ access; register it once more for a clean output.
      result_pending  <= state == READ;
      read_data_valid <= result_pending;
      if (result_pending) read_data <= mem_read_data;
    end
  end
  // Queue storage needs no reset: count/head/tail define which entries are live.
  always_ff @(posedge system_clock) begin
    if (push) begin
      fifo_addr[tail] <= base_address;
      fifo_data[tail] <= pixel_data;
    end
  end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed table, corner sequences and random stimulus against a queue-based reference model.
module tb_framebuffer_arbiter;
  localparam int FBD = 76800;
  logic        system_clock = 1'b0;
  logic        reset, write_address_load, pixel_valid, read_request;
  logic [16:0] write_address, read_address;
  logic [11:0] pixel_data, read_data, mem_write_data, mem_read_data;
  logic        fifo_full, pixel_overflow, read_data_valid, mem_enable, mem_write_enable;
  logic [16:0] mem_address;
  always #5 system_clock = ~system_clock;
  framebuffer_arbiter dut (
    .system_clock(system_clock), .reset(reset),
    .write_address_load(write_address_load), .write_address(write_address),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .fifo_full(fifo_full), .pixel_overflow(pixel_overflow),
    .read_request(read_request), .read_address(read_address),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );
  logic [11:0] sram [int];
  always @(posedge system_clock) begin
    if (mem_enable) begin
      if (mem_write_enable) sram[int'(mem_address)] = mem_write_data;
      else mem_read_data <= sram.exists(int'(mem_address)) ? sram[int'(mem_address)] : mem_address[11:0];
    end
  end
  typedef struct {logic [16:0] a; logic [11:0] d;} ent_t;
  typedef struct {logic v; logic [11:0] d;} rd_t;
  typedef struct {
    logic r, ld; logic [16:0] wa; logic pv; logic [11:0] pd; logic rr; logic [16:0] ra;
    logic me, we; logic [16:0] ma; logic [11:0] md;
  } vec_t;
  int tests = 0, fails = 0, cyc = 0;
  int obs_writes, obs_me, obs_rdv, first_rdv;
  logic [11:0] got[$];
  ent_t q[$];
  rd_t pipe[$];
  logic [11:0] ref_mem [int];
  logic [16:0] m_ptr, m_addr;
  logic [11:0] m_wd;
  logic m_ovf, m_me, m_we;
  function automatic logic [11:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a[11:0];
  endfunction
  function automatic vec_t mk(input logic r, ld, input logic [16:0] wa, input logic pv,
                              input logic [11:0] pd, input logic rr, input logic [16:0] ra);
    vec_t v;
    v = '{r, ld, wa, pv, pd, rr, ra, 1'b0, 1'b0, 17'h0, 12'h0};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    pipe = '{'{1'b0, 12'h0}, '{1'b0, 12'h0}, '{1'b0, 12'h0}};
    m_ptr = 0; m_ovf = 0; m_me = 0; m_we = 0; m_addr = 0; m_wd = 0;
  endtask
  task automatic model_update(input vec_t v);
    bit full;
    logic [16:0] base;
    ent_t e;
    rd_t p;
    full = q.size() == 4;
    p = '{1'b0, 12'h0};
    if (v.rr) begin
      m_me = 1; m_we = 0; m_addr = v.ra;
      p = '{1'b1, ref_rd(v.ra)};
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_me = 1; m_we = 1; m_addr = e.a; m_wd = e.d;
      ref_mem[int'(e.a)] = e.d;
    end else begin
      m_me = 0; m_we = 0;
    end
    pipe.push_back(p);
    void'(pipe.pop_front());
    base = v.ld ? v.wa : m_ptr;
    if (v.ld) m_ovf = 0;
    if (v.pv && !full) begin
      q.push_back('{base, v.pd});
      m_ptr = (int'(base) == FBD - 1) ? 17'd0 : base + 17'd1;
    end else begin
      m_ptr = base;
      if (v.pv && !v.ld) m_ovf = 1;
    end
  endtask
  task automatic step(input vec_t v, input bit use_exp);
    reset = v.r; write_address_load = v.ld; write_address = v.wa;
    pixel_valid = v.pv; pixel_data = v.pd; read_request = v.rr; read_address = v.ra;
    if (v.r) model_reset();
    @(negedge system_clock);
    chk("fifo_full", fifo_full, q.size() == 4);
    chk("pixel_overflow", pixel_overflow, m_ovf);
    chk("mem_enable", mem_enable, m_me);
    chk("mem_write_enable", mem_write_enable, m_we);
    chk("mem_address", mem_address, m_addr);
    if (m_we) chk("mem_write_data", mem_write_data, m_wd);
    chk("read_data_valid", read_data_valid, pipe[0].v);
    if (pipe[0].v || v.r) chk("read_data", read_data, pipe[0].d);
    if (use_exp) begin
      chk("tbl_mem_enable", mem_enable, v.me);
      chk("tbl_mem_write_enable", mem_write_enable, v.we);
      if (v.me) chk("tbl_mem_address", mem_address, v.ma);
      if (v.we) chk("tbl_mem_write_data", mem_write_data, v.md);
    end
    if (mem_enable && mem_write_enable) obs_writes++;
    if (mem_enable) obs_me++;
    if (read_data_valid) begin
      obs_rdv++;
      got.push_back(read_data);
      if (first_rdv < 0) first_rdv = cyc;
    end
    if (!v.r) model_update(v);
    @(posedge system_clock);
    #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0), 0);
  endtask
  vec_t tbl[16];
  initial begin
    int start;
    vec_t v;
    bit heavy;
    first_rdv = -1;
    tbl[0]  = '{0, 1, 17'h100,   1, 12'hABC, 0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[1]  = '{0, 0, 17'h0,     1, 12'h123, 0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[2]  = '{0, 0, 17'h0,     1, 12'hFFF, 0, 17'h0,   1, 1, 17'h100,   12'hABC};
    tbl[3]  = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 1, 17'h101,   12'h123};
    tbl[4]  = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 1, 17'h102,   12'hFFF};
    tbl[5]  = '{0, 1, 17'h12BFF, 1, 12'hAAA, 0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[6]  = '{0, 0, 17'h0,     1, 12'h555, 0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[7]  = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 1, 17'h12BFF, 12'hAAA};
    tbl[8]  = '{0, 1, 17'h20,    1, 12'h111, 0, 17'h0,   1, 1, 17'h0,     12'h555};
    tbl[9]  = '{0, 0, 17'h0,     1, 12'h222, 0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[10] = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 1, 17'h20,    12'h111};
    tbl[11] = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 1, 17'h21,    12'h222};
    tbl[12] = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   0, 0, 17'h0,     12'h0};
    tbl[13] = '{0, 0, 17'h0,     0, 12'h0,   1, 17'h0AB, 0, 0, 17'h0,     12'h0};
    tbl[14] = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   1, 0, 17'h0AB,   12'h0};
    tbl[15] = '{0, 0, 17'h0,     0, 12'h0,   0, 17'h0,   0, 0, 17'h0,     12'h0};
    model_reset();
    step(mk(1, 0, 0, 0, 0, 0, 0), 0);
    step(mk(1, 0, 0, 0, 0, 0, 0), 0);
    idle(2);
    start = cyc;
    got.delete();
    for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 0, 0, 1, 17'(i)), 0);
    idle(5);
    chk("read_first_latency", first_rdv - start, 3);
    chk("read_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("read_order", got[i], i);
    for (int i = 0; i < 16; i++) step(tbl[i], 1);
    idle(3);
    for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 1, 12'(12'h700 + i), 1, 17'(17'h300 + i)), 0);
    step(mk(0, 0, 0, 0, 0, 1, 17'h305), 0);
    chk("ovf_full_held", fifo_full, 1);
    chk("ovf_flag_set", pixel_overflow, 1);
    obs_writes = 0;
    idle(7);
    chk("ovf_drain_writes", obs_writes, 4);
    chk("ovf_flag_sticky", pixel_overflow, 1);
    step(mk(0, 1, 17'h0, 0, 0, 0, 0), 0);
    chk("ovf_flag_load_clear", pixel_overflow, 0);
    idle(3);
    step(mk(0, 0, 0, 1, 12'h001, 1, 17'h5), 0);
    step(mk(0, 0, 0, 1, 12'h002, 1, 17'h6), 0);
    step(mk(1, 0, 0, 0, 0, 0, 0), 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_read_valid", read_data_valid, 0);
    chk("rst_fifo_full", fifo_full, 0);
    obs_me = 0;
    obs_rdv = 0;
    idle(6);
    chk("rst_no_mem_after", obs_me, 0);
    chk("rst_no_rdv_after", obs_rdv, 0);
    heavy = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) heavy = $urandom_range(0, 1) == 1;
      v = mk($urandom_range(0, 399) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 1) ? 17'(FBD - 1 - $urandom_range(0, 2)) : 17'($urandom_range(0, FBD - 1)),
             $urandom_range(0, 2) == 0, 12'($urandom),
             heavy ? $urandom_range(0, 7) != 0 : $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) ? 17'($urandom_range(0, 15)) : 17'($urandom_range(0, FBD - 1)));
      step(v, 0);
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
